// File: rtl/hasti_arbiter2_pkg.sv
// Shared AHB-Lite (HASTI) encodings and arbiter types for the two-master arbiter.
// Address-phase control is carried as one packed struct so the holding registers stay generic.
package hasti_arbiter2_pkg;

  localparam int HASTI_DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_B8    = 3'b000,
    HSIZE_B16   = 3'b001,
    HSIZE_B32   = 3'b010,
    HSIZE_B64   = 3'b011,
    HSIZE_B128  = 3'b100,
    HSIZE_B256  = 3'b101,
    HSIZE_B512  = 3'b110,
    HSIZE_B1024 = 3'b111
  } hsize_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic     hwrite;
    hsize_t   hsize;
    hburst_t  hburst;
    logic [3:0] hprot;
    logic     hmastlock;
    htrans_t  htrans;
  } hasti_ctl_t;

  function automatic logic is_live(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/hasti_arb_hold.sv
// Per-master holding register: parks a losing address phase and replays it ahead of
// whatever the master is currently driving.
module hasti_arb_hold
  import hasti_arbiter2_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] live_addr,
  input  hasti_ctl_t        live_ctl,
  output logic              pend_v,
  output logic [ADDR_W-1:0] sel_addr,
  output hasti_ctl_t        sel_ctl
);

  logic              pend_v_r;
  logic [ADDR_W-1:0] pend_addr_r;
  hasti_ctl_t        pend_ctl_r;

  // Capture the parked request on load; drop the valid flag once it has been granted.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend_v_r    <= 1'b0;
      pend_addr_r <= '0;
      pend_ctl_r  <= '0;
    end else if (load) begin
      pend_v_r    <= 1'b1;
      pend_addr_r <= live_addr;
      pend_ctl_r  <= live_ctl;
    end else if (clear) begin
      pend_v_r    <= 1'b0;
    end else begin
      pend_v_r    <= pend_v_r;
    end
  end

  assign pend_v   = pend_v_r;
  assign sel_addr = pend_v_r ? pend_addr_r : live_addr;
  assign sel_ctl  = pend_v_r ? pend_ctl_r  : live_ctl;

endmodule

// File: rtl/hasti_arbiter2.sv
// Two-master to one-slave AHB-Lite arbiter: grants each slave address phase, parks and
// stalls the loser, and steers data/response by the owner of the current data phase.
module hasti_arbiter2
  import hasti_arbiter2_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [ADDR_W-1:0]       m0_haddr,
  input  logic                    m0_hwrite,
  input  logic [2:0]              m0_hsize,
  input  logic [2:0]              m0_hburst,
  input  logic [3:0]              m0_hprot,
  input  logic [1:0]              m0_htrans,
  input  logic                    m0_hmastlock,
  input  logic [HASTI_DATA_W-1:0] m0_hwdata,
  output logic [HASTI_DATA_W-1:0] m0_hrdata,
  output logic                    m0_hready,
  output logic                    m0_hresp,
  input  logic [ADDR_W-1:0]       m1_haddr,
  input  logic                    m1_hwrite,
  input  logic [2:0]              m1_hsize,
  input  logic [2:0]              m1_hburst,
  input  logic [3:0]              m1_hprot,
  input  logic [1:0]              m1_htrans,
  input  logic                    m1_hmastlock,
  input  logic [HASTI_DATA_W-1:0] m1_hwdata,
  output logic [HASTI_DATA_W-1:0] m1_hrdata,
  output logic                    m1_hready,
  output logic                    m1_hresp,
  output logic [ADDR_W-1:0]       s_haddr,
  output logic                    s_hwrite,
  output logic [2:0]              s_hsize,
  output logic [2:0]              s_hburst,
  output logic [3:0]              s_hprot,
  output logic [1:0]              s_htrans,
  output logic                    s_hmastlock,
  output logic [HASTI_DATA_W-1:0] s_hwdata,
  input  logic [HASTI_DATA_W-1:0] s_hrdata,
  input  logic                    s_hready,
  input  logic                    s_hresp
);

  hasti_ctl_t        live_ctl_s [0:1];
  hasti_ctl_t        sel_ctl_s  [0:1];
  logic [ADDR_W-1:0] sel_addr_s [0:1];
  logic [1:0]        pend_v_s;
  logic [1:0]        live_s;
  logic [1:0]        req_s;
  logic [1:0]        load_s;
  logic [1:0]        clear_s;
  logic [1:0]        lose_s;
  owner_t            winner_s;
  owner_t            grant_s;
  owner_t            addr_sel_s;
  hasti_ctl_t        ctl_s;
  logic [ADDR_W-1:0] addr_s;
  owner_t            downer_r;
  owner_t            last_r;
  owner_t            lock_own_r;
  owner_t            sel_r;

  assign live_ctl_s[0] = '{hwrite: m0_hwrite, hsize: hsize_t'(m0_hsize),
                           hburst: hburst_t'(m0_hburst), hprot: m0_hprot,
                           hmastlock: m0_hmastlock, htrans: htrans_t'(m0_htrans)};
  assign live_ctl_s[1] = '{hwrite: m1_hwrite, hsize: hsize_t'(m1_hsize),
                           hburst: hburst_t'(m1_hburst), hprot: m1_hprot,
                           hmastlock: m1_hmastlock, htrans: htrans_t'(m1_htrans)};

  assign live_s[0] = is_live(live_ctl_s[0].htrans);
  assign live_s[1] = is_live(live_ctl_s[1].htrans);
  assign req_s     = pend_v_s | live_s;

  hasti_arb_hold #(.ADDR_W(ADDR_W)) u_hold0 (
    .hclk(hclk), .hresetn(hresetn), .load(load_s[0]), .clear(clear_s[0]),
    .live_addr(m0_haddr), .live_ctl(live_ctl_s[0]), .pend_v(pend_v_s[0]),
    .sel_addr(sel_addr_s[0]), .sel_ctl(sel_ctl_s[0])
  );

  hasti_arb_hold #(.ADDR_W(ADDR_W)) u_hold1 (
    .hclk(hclk), .hresetn(hresetn), .load(load_s[1]), .clear(clear_s[1]),
    .live_addr(m1_haddr), .live_ctl(live_ctl_s[1]), .pend_v(pend_v_s[1]),
    .sel_addr(sel_addr_s[1]), .sel_ctl(sel_ctl_s[1])
  );

  // Winner selection: lock owner first, then a lone requester, then the tie-break.
  always_comb begin
    winner_s = OWN_NONE;
    if ((lock_own_r == OWN_M0) && req_s[0]) begin
      winner_s = OWN_M0;
    end else if ((lock_own_r == OWN_M1) && req_s[1]) begin
      winner_s = OWN_M1;
    end else if (req_s == 2'b11) begin
      winner_s = ((ROUND_ROBIN != 32'sd0) && (last_r == OWN_M0)) ? OWN_M1 : OWN_M0;
    end else if (req_s[0]) begin
      winner_s = OWN_M0;
    end else if (req_s[1]) begin
      winner_s = OWN_M1;
    end else begin
      winner_s = OWN_NONE;
    end
  end

  // Grants exist only while the slave accepts an address and reset is released.
  assign grant_s    = (s_hready && hresetn) ? winner_s : OWN_NONE;
  assign addr_sel_s = (grant_s != OWN_NONE) ? grant_s : sel_r;

  assign clear_s[0] = (grant_s == OWN_M0);
  assign clear_s[1] = (grant_s == OWN_M1);
  assign load_s[0]  = s_hready & live_s[0] & ~pend_v_s[0] & (grant_s != OWN_M0);
  assign load_s[1]  = s_hready & live_s[1] & ~pend_v_s[1] & (grant_s != OWN_M1);
  assign lose_s[0]  = hresetn & live_s[0] & (grant_s != OWN_M0);
  assign lose_s[1]  = hresetn & live_s[1] & (grant_s != OWN_M1);

  // Slave address-phase mux; non-htrans fields keep the last selected master when idle.
  always_comb begin
    case (addr_sel_s)
      OWN_M1: begin
        ctl_s  = sel_ctl_s[1];
        addr_s = sel_addr_s[1];
      end
      default: begin
        ctl_s  = sel_ctl_s[0];
        addr_s = sel_addr_s[0];
      end
    endcase
  end

  assign s_haddr     = addr_s;
  assign s_hwrite    = ctl_s.hwrite;
  assign s_hsize     = ctl_s.hsize;
  assign s_hburst    = ctl_s.hburst;
  assign s_hprot     = ctl_s.hprot;
  assign s_hmastlock = ctl_s.hmastlock;
  assign s_htrans    = (grant_s == OWN_NONE) ? HTRANS_IDLE : ctl_s.htrans;

  // Arbitration state advances only on cycles where the slave completes a transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      downer_r   <= OWN_NONE;
      last_r     <= OWN_M1;
      lock_own_r <= OWN_NONE;
      sel_r      <= OWN_M0;
    end else if (s_hready) begin
      downer_r   <= grant_s;
      lock_own_r <= ((grant_s != OWN_NONE) && ctl_s.hmastlock) ? grant_s : OWN_NONE;
      if (grant_s != OWN_NONE) begin
        last_r <= grant_s;
        sel_r  <= grant_s;
      end else begin
        last_r <= last_r;
        sel_r  <= sel_r;
      end
    end else begin
      downer_r   <= downer_r;
      last_r     <= last_r;
      lock_own_r <= lock_own_r;
      sel_r      <= sel_r;
    end
  end

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  // Data-phase steering and per-master stall generation.
  always_comb begin
    case (downer_r)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = {HASTI_DATA_W{1'b0}};
    endcase
    m0_hresp = (downer_r == OWN_M0) ? s_hresp : HRESP_OKAY;
    m1_hresp = (downer_r == OWN_M1) ? s_hresp : HRESP_OKAY;
    if (downer_r == OWN_M0) begin
      m0_hready = s_hready;
    end else if (pend_v_s[0] | lose_s[0]) begin
      m0_hready = 1'b0;
    end else begin
      m0_hready = 1'b1;
    end
    if (downer_r == OWN_M1) begin
      m1_hready = s_hready;
    end else if (pend_v_s[1] | lose_s[1]) begin
      m1_hready = 1'b0;
    end else begin
      m1_hready = 1'b1;
    end
  end

endmodule

// File: tb/tb_hasti_arbiter2.sv
// Scenario bench for hasti_arbiter2: expected slave addresses queue up as masters issue
// and are popped as the slave sees each granted address phase.
module tb_hasti_arbiter2;

  logic        hclk, hresetn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        s_hready, s_hresp;
  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic        m0_hready, m0_hresp, m1_hready, m1_hresp, s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [31:0] r0_m0_hrdata, r0_m1_hrdata, r0_s_haddr, r0_s_hwdata;
  logic        r0_m0_hready, r0_m0_hresp, r0_m1_hready, r0_m1_hresp, r0_s_hwrite, r0_s_hmastlock;
  logic [2:0]  r0_s_hsize, r0_s_hburst;
  logic [3:0]  r0_s_hprot;
  logic [1:0]  r0_s_htrans;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];
  logic [31:0] exp_a;

  hasti_arbiter2 #(.ROUND_ROBIN(1), .ADDR_W(32)) u_dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_htrans(m0_htrans), .m0_hmastlock(m0_hmastlock),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_htrans(m1_htrans), .m1_hmastlock(m1_hmastlock),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  hasti_arbiter2 #(.ROUND_ROBIN(0), .ADDR_W(32)) u_dut_rr0 (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_htrans(m0_htrans), .m0_hmastlock(m0_hmastlock),
    .m0_hwdata(m0_hwdata), .m0_hrdata(r0_m0_hrdata), .m0_hready(r0_m0_hready), .m0_hresp(r0_m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_htrans(m1_htrans), .m1_hmastlock(m1_hmastlock),
    .m1_hwdata(m1_hwdata), .m1_hrdata(r0_m1_hrdata), .m1_hready(r0_m1_hready), .m1_hresp(r0_m1_hresp),
    .s_haddr(r0_s_haddr), .s_hwrite(r0_s_hwrite), .s_hsize(r0_s_hsize), .s_hburst(r0_s_hburst),
    .s_hprot(r0_s_hprot), .s_htrans(r0_s_htrans), .s_hmastlock(r0_s_hmastlock), .s_hwdata(r0_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  function automatic logic [31:0] sb_pop();
    if (sb_q.size() == 0) return 32'hxxxx_xxxx;
    return sb_q.pop_front();
  endfunction

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_m(input int idx, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic lock);
    if (idx == 0) begin
      m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hmastlock = lock;
      m0_hsize = 3'b010; m0_hburst = 3'b000; m0_hprot = 4'b0011;
    end else begin
      m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hmastlock = lock;
      m1_hsize = 3'b010; m1_hburst = 3'b000; m1_hprot = 4'b0011;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drive_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    idle_all();
    @(posedge hclk);
    @(posedge hclk);
    #1 hresetn = 1'b1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    idle_all();
    drive_m(0, 2'b10, 32'h44, 1'b0, 1'b0);
    drive_m(1, 2'b10, 32'h48, 1'b0, 1'b0);
    m1_hwdata = 32'h1111_2222;
    #2;
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h want 0", s_htrans); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL rst_m0_hready got %b want 1", m0_hready); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL rst_m1_hready got %b want 1", m1_hready); end
    checks++; if (s_hwdata !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h want 0", s_hwdata); end
    next_cycle();
    hresetn = 1'b1;
    idle_all();
    #2;
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL rst_post_htrans got %h want 0", s_htrans); end
    next_cycle();
  endtask

  task automatic test_single();
    drive_m(0, 2'b10, 32'h0000_0010, 1'b0, 1'b0);
    sb_q.push_back(32'h0000_0010);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL single_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_htrans !== 2'b10) begin errors++; $display("FAIL single_htrans got %h want 2", s_htrans); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL single_m0_hready_a got %b want 1", m0_hready); end
    next_cycle();
    idle_all();
    s_hrdata = 32'hCAFE_0010;
    #2;
    checks++; if (m0_hrdata !== 32'hCAFE_0010) begin errors++; $display("FAIL single_hrdata got %h want cafe0010", m0_hrdata); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL single_m0_hready_d got %b want 1", m0_hready); end
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL single_idle got %h want 0", s_htrans); end
    next_cycle();
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    drive_m(0, 2'b10, 32'h100, 1'b0, 1'b0);
    drive_m(1, 2'b10, 32'h200, 1'b1, 1'b0);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h200);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL tie0_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL tie0_m1_hready got %b want 0", m1_hready); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL tie0_m0_hready got %b want 1", m0_hready); end
    next_cycle();
    drive_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    drive_m(0, 2'b10, 32'h104, 1'b0, 1'b0);
    sb_q.push_back(32'h104);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL tie1_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_hwrite !== 1'b1) begin errors++; $display("FAIL tie1_hwrite got %b want 1", s_hwrite); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL tie1_m1_hready got %b want 0", m1_hready); end
    next_cycle();
    drive_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    m1_hwdata = 32'h1234_5678;
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL tie2_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_hwdata !== 32'h1234_5678) begin errors++; $display("FAIL tie2_hwdata got %h want 12345678", s_hwdata); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL tie2_m1_hready got %b want 1", m1_hready); end
    checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL tie2_m0_hready got %b want 0", m0_hready); end
    next_cycle();
    idle_all();
    #2;
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL tie3_m0_hready got %b want 1", m0_hready); end
    next_cycle();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_m(0, 2'b10, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
      if (k == 0) drive_m(1, 2'b10, 32'h400, 1'b0, 1'b0);
      else drive_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
      sb_q.push_back(32'h300 + 32'(4 * k));
      #2;
      exp_a = sb_pop();
      checks++; if (r0_s_haddr !== exp_a) begin errors++; $display("FAIL fixed_haddr_%0d got %h want %h", k, r0_s_haddr, exp_a); end
      checks++; if (r0_m1_hready !== 1'b0) begin errors++; $display("FAIL fixed_m1_hready_%0d got %b want 0", k, r0_m1_hready); end
      checks++; if (r0_m0_hready !== 1'b1) begin errors++; $display("FAIL fixed_m0_hready_%0d got %b want 1", k, r0_m0_hready); end
      next_cycle();
    end
    drive_m(0, 2'b00, 32'h0, 1'b0, 1'b0);
    sb_q.push_back(32'h400);
    #2;
    exp_a = sb_pop();
    checks++; if (r0_s_haddr !== exp_a) begin errors++; $display("FAIL fixed_m1_haddr got %h want %h", r0_s_haddr, exp_a); end
    checks++; if (r0_s_htrans !== 2'b10) begin errors++; $display("FAIL fixed_m1_htrans got %h want 2", r0_s_htrans); end
    next_cycle();
    #2;
    checks++; if (r0_m1_hready !== 1'b1) begin errors++; $display("FAIL fixed_m1_done got %b want 1", r0_m1_hready); end
    next_cycle();
  endtask

  task automatic test_wait_states();
    do_reset();
    drive_m(1, 2'b10, 32'h500, 1'b1, 1'b0);
    sb_q.push_back(32'h500);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL wait_m1_haddr got %h want %h", s_haddr, exp_a); end
    next_cycle();
    drive_m(1, 2'b00, 32'h0, 1'b0, 1'b0);
    m1_hwdata = 32'hDEAD_BEEF;
    drive_m(0, 2'b10, 32'h600, 1'b0, 1'b0);
    sb_q.push_back(32'h600);
    s_hready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #2;
      checks++; if (s_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_hwdata_%0d got %h want deadbeef", w, s_hwdata); end
      checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL wait_htrans_%0d got %h want 0", w, s_htrans); end
      checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL wait_m0_hready_%0d got %b want 0", w, m0_hready); end
      checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL wait_m1_hready_%0d got %b want 0", w, m1_hready); end
      next_cycle();
    end
    s_hready = 1'b1;
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL wait_m0_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_hwdata_end got %h want deadbeef", s_hwdata); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL wait_m1_done got %b want 1", m1_hready); end
    next_cycle();
    idle_all();
  endtask

  task automatic test_error();
    do_reset();
    drive_m(0, 2'b10, 32'h7F0, 1'b0, 1'b0);
    sb_q.push_back(32'h7F0);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL err0_haddr got %h want %h", s_haddr, exp_a); end
    next_cycle();
    drive_m(0, 2'b10, 32'h800, 1'b0, 1'b0);
    drive_m(1, 2'b10, 32'h700, 1'b0, 1'b0);
    sb_q.push_back(32'h700);
    sb_q.push_back(32'h800);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL err1_haddr got %h want %h", s_haddr, exp_a); end
    next_cycle();
    idle_all();
    s_hready = 1'b0; s_hresp = 1'b1;
    #2;
    checks++; if (m1_hresp !== 1'b1) begin errors++; $display("FAIL err2_m1_hresp got %b want 1", m1_hresp); end
    checks++; if (m0_hresp !== 1'b0) begin errors++; $display("FAIL err2_m0_hresp got %b want 0", m0_hresp); end
    checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL err2_m0_hready got %b want 0", m0_hready); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL err2_m1_hready got %b want 0", m1_hready); end
    next_cycle();
    s_hready = 1'b1;
    #2;
    exp_a = sb_pop();
    checks++; if (m1_hresp !== 1'b1) begin errors++; $display("FAIL err3_m1_hresp got %b want 1", m1_hresp); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL err3_m1_hready got %b want 1", m1_hready); end
    checks++; if (m0_hresp !== 1'b0) begin errors++; $display("FAIL err3_m0_hresp got %b want 0", m0_hresp); end
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL err3_replay_haddr got %h want %h", s_haddr, exp_a); end
    next_cycle();
    s_hresp = 1'b0;
    #2;
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL err4_m0_hready got %b want 1", m0_hready); end
    next_cycle();
  endtask

  task automatic test_lock();
    do_reset();
    drive_m(1, 2'b10, 32'hD00, 1'b0, 1'b1);
    sb_q.push_back(32'hD00);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL lock0_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_hmastlock !== 1'b1) begin errors++; $display("FAIL lock0_hmastlock got %b want 1", s_hmastlock); end
    next_cycle();
    drive_m(1, 2'b10, 32'hD04, 1'b0, 1'b1);
    drive_m(0, 2'b10, 32'hE00, 1'b0, 1'b0);
    sb_q.push_back(32'hD04);
    sb_q.push_back(32'hE00);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL lock1_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL lock1_m0_hready got %b want 0", m0_hready); end
    next_cycle();
    idle_all();
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL lock2_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (s_hmastlock !== 1'b0) begin errors++; $display("FAIL lock2_hmastlock got %b want 0", s_hmastlock); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m(0, 2'b10, 32'h900, 1'b0, 1'b0);
    drive_m(1, 2'b10, 32'hA00, 1'b0, 1'b0);
    sb_q.push_back(32'h900);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL rmid0_haddr got %h want %h", s_haddr, exp_a); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL rmid0_m1_hready got %b want 0", m1_hready); end
    next_cycle();
    idle_all();
    m0_hwdata = 32'h5555_AAAA;
    hresetn = 1'b0;
    #2;
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL rmid_htrans got %h want 0", s_htrans); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL rmid_m1_hready got %b want 1", m1_hready); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL rmid_m0_hready got %b want 1", m0_hready); end
    checks++; if (s_hwdata !== 32'h0) begin errors++; $display("FAIL rmid_hwdata got %h want 0", s_hwdata); end
    next_cycle();
    hresetn = 1'b1;
    m0_hwdata = 32'h0;
    #2;
    checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL rmid_no_replay got %h want 0", s_htrans); end
    next_cycle();
    drive_m(0, 2'b10, 32'hB00, 1'b0, 1'b0);
    drive_m(1, 2'b10, 32'hC00, 1'b0, 1'b0);
    sb_q.push_back(32'hB00);
    #2;
    exp_a = sb_pop();
    checks++; if (s_haddr !== exp_a) begin errors++; $display("FAIL rmid_tie_haddr got %h want %h", s_haddr, exp_a); end
    next_cycle();
    idle_all();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    hresetn = 1'b0;
    idle_all();
    @(posedge hclk);
    #1;
    test_reset();
    test_single();
    test_tie_round_robin();
    test_fixed_priority();
    test_wait_states();
    test_error();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
